// File: rtl/half_adder_lanes.sv
// half_adder_lanes: per-lane half adders feeding a 2-entry (head + skid) output buffer.
// Only the {sum, carry} pairs are buffered. in_ready, out_valid, sum and carry are all driven directly from flops.
module half_adder_lanes #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  // Pair layout: carry in the upper WIDTH bits, sum in the lower WIDTH bits.
  function automatic logic [2*WIDTH-1:0] half_add(input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y);
    return {x & y, x ^ y};
  endfunction

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] head_q, head_d;
  logic [2*WIDTH-1:0] skid_q, skid_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [2*WIDTH-1:0] new_pair;
  logic               accept;
  logic               retire;

  assign new_pair = half_add(a, b);
  assign accept   = in_valid & in_ready_q;
  assign retire   = out_valid_q & out_ready;

  // Occupancy next-state and buffer steering.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          head_d  = new_pair;
          state_d = ONE;
        end else begin
          state_d = EMPTY;
        end
      end
      ONE: begin
        if (accept && retire) begin
          head_d  = new_pair;
          state_d = ONE;
        end else if (accept) begin
          skid_d  = new_pair;
          state_d = TWO;
        end else if (retire) begin
          state_d = EMPTY;
        end else begin
          state_d = ONE;
        end
      end
      TWO: begin
        // in_ready is low here, so the only possible event is a retire.
        if (retire) begin
          head_d  = skid_q;
          state_d = ONE;
        end else begin
          state_d = TWO;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
    in_ready_d  = (state_d != TWO);
    out_valid_d = (state_d != EMPTY);
  end

  // State and output registers; reset drops every held beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      head_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = head_q[WIDTH-1:0];
  assign carry     = head_q[2*WIDTH-1:WIDTH];

endmodule

// File: tb/tb_half_adder_lanes.sv
// Scoreboard bench for half_adder_lanes: a WIDTH=4 instance plus a WIDTH=1 instance that mirrors lane 0.
module tb_half_adder_lanes;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [W-1:0]   a, b;
  logic           in_valid, out_ready;
  logic           in_ready4, out_valid4;
  logic [W-1:0]   sum4, carry4;
  logic           in_ready1, out_valid1;
  logic [0:0]     sum1, carry1;
  logic [0:0]     a1, b1;

  int             checks   = 0;
  int             failures = 0;
  logic [2*W-1:0] sb_q[$];
  logic [2*W-1:0] last_ret;
  logic           model_rdy;

  always #5 clk = ~clk;

  assign a1 = a[0:0];
  assign b1 = b[0:0];

  half_adder_lanes #(.WIDTH(W)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid), .in_ready(in_ready4),
    .sum(sum4), .carry(carry4), .out_valid(out_valid4), .out_ready(out_ready)
  );

  half_adder_lanes #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(in_valid), .in_ready(in_ready1),
    .sum(sum1), .carry(carry1), .out_valid(out_valid1), .out_ready(out_ready)
  );

  // Expected pair built from 2-bit per-lane addition: carry bits high, sum bits low.
  function automatic logic [2*W-1:0] expect_pair(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] r;
    logic [1:0]     s2;
    r = '0;
    for (int i = 0; i < W; i++) begin
      s2       = {1'b0, x[i]} + {1'b0, y[i]};
      r[i]     = s2[0];
      r[W+i]   = s2[1];
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called mid-cycle: compare outputs with the model, apply the handshakes, advance one clock.
  task automatic tick();
    logic [2*W-1:0] hd;
    hd = (sb_q.size() > 0) ? sb_q[0] : last_ret;
    check("in_ready",     8'(in_ready4),  8'(model_rdy));
    check("out_valid",    8'(out_valid4), 8'(sb_q.size() > 0));
    check("sum",          8'(sum4),       8'(hd[W-1:0]));
    check("carry",        8'(carry4),     8'(hd[2*W-1:W]));
    check("w1_in_ready",  8'(in_ready1),  8'(model_rdy));
    check("w1_out_valid", 8'(out_valid1), 8'(sb_q.size() > 0));
    check("w1_sum",       8'(sum1),       8'(hd[0]));
    check("w1_carry",     8'(carry1),     8'(hd[W]));
    if (sb_q.size() > 0 && out_ready) last_ret = sb_q.pop_front();
    if (in_valid && model_rdy) sb_q.push_back(expect_pair(a, b));
    @(posedge clk);
    #1;
    model_rdy = (sb_q.size() < 2);
    @(negedge clk);
  endtask

  // Asserts rst_n between clock edges and checks that the outputs clear without any edge.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    last_ret  = '0;
    model_rdy = 1'b0;
    check("rst_out_valid", 8'(out_valid4), 8'd0);
    check("rst_sum",       8'(sum4),       8'd0);
    check("rst_carry",     8'(carry4),     8'd0);
    check("rst_in_ready",  8'(in_ready4),  8'd0);
    check("rst_w1_valid",  8'(out_valid1), 8'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [1:0] combo;
    rst_n     = 1'b0;
    a         = '0;
    b         = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    last_ret  = '0;
    model_rdy = 1'b0;
    #1;
    check("por_out_valid", 8'(out_valid4), 8'd0);
    check("por_in_ready",  8'(in_ready4),  8'd0);
    check("por_sum",       8'(sum4),       8'd0);
    check("por_carry",     8'(carry4),     8'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // All four single-bit combinations, driven on every lane, with out_ready high.
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      combo    = 2'(k);
      a        = {W{combo[1]}};
      b        = {W{combo[0]}};
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
    end

    // Four independent lanes: no carry may ripple between them.
    a        = 4'b1100;
    b        = 4'b1010;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("lanes_sum",   8'(sum4),   8'h06);
    check("lanes_carry", 8'(carry4), 8'h08);
    tick();

    // Backpressure: offer three beats with out_ready low; only two may be absorbed.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a = 4'($urandom);
      b = 4'($urandom);
      tick();
    end
    check("bp_in_ready_low", 8'(in_ready4), 8'd0);
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) tick();

    // Random streaming under random backpressure.
    for (int k = 0; k < 300; k++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      a         = 4'($urandom);
      b         = 4'($urandom);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) tick();

    // Fill both entries, then assert reset asynchronously mid-stream.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a         = 4'b1111;
    b         = 4'b1101;
    tick();
    a         = 4'b1011;
    b         = 4'b0110;
    tick();
    in_valid = 1'b0;
    async_reset();
    tick();
    out_ready = 1'b1;
    a         = 4'b0111;
    b         = 4'b0011;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    check("post_rst_sum",   8'(sum4),   8'h04);
    check("post_rst_carry", 8'(carry4), 8'h03);
    tick();
    tick();

    // Idle with a/b toggling: nothing accepted, outputs hold the last retired pair.
    for (int k = 0; k < 10; k++) begin
      a = 4'($urandom);
      b = 4'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/half_adder_lanes.md
# half_adder_lanes

Per-lane half-adder bank with one registered output stage and a valid/ready handshake. Each lane computes sum = a XOR b and carry = a AND b. The stage uses a 2-entry skid buffer so that `in_ready` is driven from a register. The block sits at the bottom of the adder hierarchy: full-adder and ripple/carry-save blocks in the datapath consume it.

## Interface
- `WIDTH`, default 1: number of independent 1-bit half-adder lanes (≥1).
- `clk` input 1: the block's single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `a` input WIDTH: addend bits, one per lane.
- `b` input WIDTH: addend bits, one per lane.
- `in_valid` input 1: `a`/`b` valid this cycle.
- `in_ready` output 1: block can accept a beat; registered.
- `sum` output WIDTH: per-lane `a[i] ^ b[i]` of the head beat.
- `carry` output WIDTH: per-lane `a[i] & b[i]` of the head beat.
- `out_valid` output 1: `sum`/`carry` hold a valid result.
- `out_ready` input 1: downstream accepts the result this cycle.

## Operation
- Arithmetic per lane i:
  - `sum[i] = a[i] XOR b[i]`; `carry[i] = a[i] AND b[i]`.
  - Lanes are fully independent, with no carry propagation between lanes.
  - `{carry[i], sum[i]}` equals `a[i] + b[i]` as a 2-bit value.
- Results are computed combinationally at input acceptance and stored.
  - A 2-entry buffer (main + skid) holds `{sum, carry}` pairs; `a`/`b` themselves are not stored.
- Input handshake: a beat is accepted when `in_valid && in_ready` at a rising edge.
- Output handshake: a beat is retired when `out_valid && out_ready` at a rising edge.
- Occupancy states:
  - EMPTY: `out_valid=0`, `in_ready=1`.
    - Accept → ONE.
  - ONE: `out_valid=1`, `in_ready=1`.
    - Accept and retire in the same cycle → ONE; the new beat replaces the head.
    - Accept only → TWO; the new beat goes to skid.
    - Retire only → EMPTY.
  - TWO: `out_valid=1`, `in_ready=0`.
    - Retire → ONE; the skid beat moves to head. No accept is possible.
- `sum`/`carry` always present the head entry; order is strictly FIFO.
- While `out_valid=1` and `out_ready=0`, `sum`/`carry` stay stable.
- While `out_valid=0`, `sum`/`carry` hold the last retired values (0 after reset).
- `in_valid` low with `a`/`b` changing has no effect on state.
- No beat is dropped or duplicated under any `in_valid`/`out_ready` pattern.

## Timing
- Reset (`rst_n` low), asynchronous and immediate, regardless of clock:
  - `out_valid=0`, `sum=0`, `carry=0`, skid cleared, state EMPTY.
  - `in_ready=0` while `rst_n` is low.
  - `in_ready` rises to 1 on the first rising edge after `rst_n` deasserts.
  - Reset mid-operation discards all held beats.
- Latency: 1 cycle.
  - A beat accepted at edge N appears with `out_valid=1` after edge N.
  - It is retirable at edge N+1.
- Throughput: 1 beat/cycle when `out_ready` is held high.
- Backpressure: with `out_ready=0`, at most 2 beats are absorbed.
  - `in_ready` falls after the edge that fills the skid entry.
  - It rises after the edge that retires a beat.
- No combinational path from `out_ready` to `in_ready`, or from inputs to outputs.

## Test plan
- Reset, then all four 1-lane combinations with `out_ready=1` (WIDTH=1):
  - (0,0)→sum=0, carry=0.
  - (0,1)→1,0.
  - (1,0)→1,0.
  - (1,1)→0,1.
  - Each result appears one cycle after acceptance.
- WIDTH=4: a=4'b1100, b=4'b1010 → sum=4'b0110, carry=4'b1000. Confirm no inter-lane carry.
- Backpressure:
  - Hold `out_ready=0` and send 3 beats.
  - Only 2 are accepted; `in_ready` drops after the 2nd.
  - Release `out_ready`; results emerge in order with values unchanged.
- Streaming: random `a`/`b` every cycle with random `out_ready`. The scoreboard matches `{carry,sum}==a+b` per lane and shows no loss or duplication.
- Async reset asserted mid-stream with the buffer in TWO:
  - `out_valid`, `sum`, `carry` go to 0 immediately without a clock edge.
  - After release, the first new beat is processed correctly.
- Idle: `in_valid=0` with toggling `a`/`b` → `out_valid` stays 0 and outputs do not change.
